stopwatch_bcd: RTL
==================

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL have parameter TICK_DIV, default 2500000: clk cycles per count tick (0.1 s at 25 MHz); legal range 2 or more.
REQ-002 SHALL have parameter NDIG, default 4: number of BCD digits; legal range 1 to 8.
REQ-003 SHALL have parameter WRAP, default 1: 1 = wrap at range limits, 0 = saturate.
REQ-004 SHALL have port clk  in  1: single clock, all state updates on its rising edge.
REQ-005 SHALL have port res  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port go  in  1: run enable; 1 = prescaler advances, 0 = paused.
REQ-007 SHALL have port clr  in  1: synchronous clear of count, prescaler, ovf and freeze.
REQ-008 SHALL have port dir  in  1: 0 = count up, 1 = count down; sampled only on tick.
REQ-009 SHALL have port load  in  1: synchronous preload strobe.
REQ-010 SHALL have port load_val  in  4*NDIG: preload value, digit i at bits [4i+3:4i], digit 0 least significant.
REQ-011 SHALL have port lap  in  1: one-cycle pulse that toggles display freeze.
REQ-012 SHALL have port d  out  4*NDIG: displayed BCD value, same digit packing as load_val.
REQ-013 SHALL have port tick  out  1: count-advance strobe.
REQ-014 SHALL have port ovf  out  1: sticky flag, set on any wrap or saturation attempt.
REQ-015 SHALL have port zero  out  1: live count equals all zeros.
REQ-016 SHALL have port frozen  out  1: display freeze active.

Function
REQ-017 SHALL implement the prescaler p, range 0 to TICK_DIV-1: when go=1 it increments; at TICK_DIV-1 it returns to 0; when go=0 it holds.
REQ-018 SHALL drive tick combinationally as go AND (p == TICK_DIV-1): exactly one cycle per TICK_DIV running cycles, with first tick TICK_DIV cycles after go rises from p=0.
REQ-019 SHALL update the live count cnt on the rising edge that ends a tick cycle: BCD +1 if dir=0, BCD -1 if dir=1, with ripple carry/borrow across all NDIG digits in the same edge.
REQ-020 SHALL keep every digit within 0 to 9 at all times: up from 9 gives 0 with carry; down from 0 gives 9 with borrow.
REQ-021 Up at all nines (10^NDIG-1) SHALL give all zeros when WRAP=1 and hold all nines when WRAP=0; ovf is set in both cases.
REQ-022 Down at all zeros SHALL give all nines when WRAP=1 and hold zero when WRAP=0; ovf is set in both cases.
REQ-023 SHALL keep ovf at 1 once set until res or clr.
REQ-024 SHALL make load (when not overridden) set cnt to load_val, with any load_val digit above 9 clamped to 9, and set p to 0; ovf and freeze are unchanged.
REQ-025 SHALL apply per-edge priority res > clr > load > tick; a lower-priority event in the same cycle is discarded, not deferred.
REQ-026 SHALL make a lap pulse (when res, clr and load are all 0) toggle frozen; on 0 to 1 it captures the snap register from the cnt value being written at that same edge, tick included.
REQ-027 SHALL drive d as snap when frozen=1 and as cnt otherwise; cnt keeps counting while frozen.
REQ-028 SHALL drive zero from cnt, never from snap.
REQ-029 SHALL make a lap in the same cycle as load be ignored.
REQ-030 SHALL give d a latency of one clk from the updating edge; there is no further pipelining.

Reset
REQ-031 SHALL, when res=1 at a rising edge, set p=0, cnt=0, snap=0, ovf=0 and frozen=0, regardless of all other inputs.
REQ-032 SHALL hold these output values for the cycle after reset: d=0, zero=1, ovf=0, frozen=0, with tick=0 unless go=1 and TICK_DIV-1==0, which is illegal.
REQ-033 SHALL handle res mid-count (including in a tick cycle) as discarding the tick, with counting resuming from 0 after TICK_DIV go cycles.

Verification
REQ-034 SHALL cover basic up-count (TICK_DIV=4, NDIG=2, WRAP=1): res, then go=1 for 40 cycles -> 10 ticks, d=0x10, ovf=0, no digit above 9 at any time.
REQ-035 SHALL cover wrap and saturate: load 0x99, dir=0, one tick -> WRAP=1 gives d=0x00 and ovf=1; WRAP=0 gives d=0x99 and ovf=1.
REQ-036 SHALL cover down-count borrow: load 0x10, dir=1, one tick -> d=0x09; a further 9 ticks -> d=0x00 and zero=1; one more tick with WRAP=1 -> d=0x99 and ovf=1.
REQ-037 SHALL cover lap freeze: count to 0x05, pulse lap -> d stays 0x05 while cnt reaches 0x08, then pulse lap -> d=0x08 and frozen=0.
REQ-038 SHALL cover priority: clr and load in the same tick cycle -> cnt=0 and ovf=0; load with load_val=0xAF -> d=0x99.
REQ-039 SHALL cover pause and reset: go=0 for 100 cycles -> no tick and d unchanged; res asserted in a tick cycle -> next d=0x00 and the first tick comes 4 go cycles later.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch: go-gated prescaler, up/down multi-digit BCD counter with
// wrap or saturate, sticky overflow, preload and lap freeze of the display.
module stopwatch_bcd #(
  parameter int TICK_DIV = 2500000,
  parameter int NDIG     = 4,
  parameter bit WRAP     = 1'b1
) (
  input  logic                clk,
  input  logic                res,
  input  logic                go,
  input  logic                clr,
  input  logic                dir,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_val,
  input  logic                lap,
  output logic [4*NDIG-1:0]   d,
  output logic                tick,
  output logic                ovf,
  output logic                zero,
  output logic                frozen
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = 4 * NDIG;

  logic [PW-1:0] p_r,    p_s;
  logic [CW-1:0] cnt_r,  cnt_s;
  logic [CW-1:0] snap_r, snap_s;
  logic          frz_r,  frz_s;
  logic          ovf_r,  ovf_s;
  logic [CW-1:0] d_r;
  logic          zero_r;
  logic          tick_s;
  logic [CW:0]   inc_s;
  logic [CW:0]   dec_s;

  // Increment with ripple carry; MSB of the result is the carry out of the top digit.
  function automatic logic [CW:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return {c, r};
  endfunction

  // Decrement with ripple borrow; MSB of the result is the borrow out of the top digit.
  function automatic logic [CW:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return {b, r};
  endfunction

  function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  assign tick_s = go && (p_r == PW'(TICK_DIV - 1));
  assign inc_s  = bcd_inc(cnt_r);
  assign dec_s  = bcd_dec(cnt_r);

  // Next-state: clr > load > (prescaler, tick, lap); lower-priority events are dropped.
  always_comb begin
    p_s    = p_r;
    cnt_s  = cnt_r;
    snap_s = snap_r;
    frz_s  = frz_r;
    ovf_s  = ovf_r;
    if (clr) begin
      p_s   = '0;
      cnt_s = '0;
      ovf_s = 1'b0;
      frz_s = 1'b0;
    end else if (load) begin
      p_s   = '0;
      cnt_s = bcd_clamp(load_val);
    end else begin
      if (go) begin
        p_s = tick_s ? '0 : p_r + PW'(1);
      end else begin
        p_s = p_r;
      end
      if (tick_s) begin
        if (!dir) begin
          if (inc_s[CW]) begin
            ovf_s = 1'b1;
            cnt_s = WRAP ? inc_s[CW-1:0] : cnt_r;
          end else begin
            cnt_s = inc_s[CW-1:0];
          end
        end else begin
          if (dec_s[CW]) begin
            ovf_s = 1'b1;
            cnt_s = WRAP ? dec_s[CW-1:0] : cnt_r;
          end else begin
            cnt_s = dec_s[CW-1:0];
          end
        end
      end else begin
        cnt_s = cnt_r;
      end
      // Snapshot takes the value being written this edge, so a same-cycle tick is included.
      if (lap) begin
        frz_s = ~frz_r;
        if (!frz_r) begin
          snap_s = cnt_s;
        end else begin
          snap_s = snap_r;
        end
      end else begin
        frz_s = frz_r;
      end
    end
  end

  // State and output registers; outputs are computed from next state so d lags by one edge only.
  always_ff @(posedge clk) begin
    if (res) begin
      p_r    <= '0;
      cnt_r  <= '0;
      snap_r <= '0;
      frz_r  <= 1'b0;
      ovf_r  <= 1'b0;
      d_r    <= '0;
      zero_r <= 1'b1;
    end else begin
      p_r    <= p_s;
      cnt_r  <= cnt_s;
      snap_r <= snap_s;
      frz_r  <= frz_s;
      ovf_r  <= ovf_s;
      d_r    <= frz_s ? snap_s : cnt_s;
      zero_r <= (cnt_s == '0);
    end
  end

  assign d      = d_r;
  assign tick   = tick_s;
  assign ovf    = ovf_r;
  assign zero   = zero_r;
  assign frozen = frz_r;

endmodule
